// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the 16-to-32-bit Wishbone bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MREQ = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Places a half-word byte-select pair on the addressed half of the 32-bit word.
    function automatic logic [3:0] steer_sel(input logic hw_hi, input logic [1:0] sel);
        return hw_hi ? {sel, 2'b00} : {2'b00, sel};
    endfunction

endpackage

// File: rtl/wb_bridge_s16_m32_if.sv
// Wishbone classic bus bundles: 16-bit and 32-bit data, 32-bit byte address.
interface wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 (input logic clk);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat_ms;
    logic [15:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    input  dat_sm, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    output dat_sm, ack, err, rty);
endinterface

interface wshb_if_DATA_BYTES_4_ADDRESS_WIDTH_32 (input logic clk);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (output cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    input  dat_sm, ack, err, rty);
    modport slave  (input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
                    output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_rdbuf.sv
// One-word read buffer: 32-bit data, 30-bit word tag, valid bit.
// Filled on read misses, patched byte-wise by writes to the same word.
module wb_rdbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_fill,
    input  logic        i_upd,
    input  logic [29:0] i_tag,
    input  logic [31:0] i_fill_data,
    input  logic [3:0]  i_upd_sel,
    input  logic [31:0] i_upd_data,
    input  logic [29:0] i_lookup_tag,
    output logic        o_hit,
    output logic [31:0] o_data
);
    logic        r_valid;
    logic [29:0] r_tag;
    logic [31:0] r_data;
    logic        w_upd_match;

    assign w_upd_match = r_valid && (r_tag == i_tag);
    assign o_hit       = r_valid && (r_tag == i_lookup_tag);
    assign o_data      = r_data;

    // Valid bit: invalidation has priority over a fill in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
        end
    end

    // Tag and data storage: whole-word fill or byte-wise write patch.
    always_ff @(posedge clk) begin
        // NOTE: tag/data carry no reset; r_valid alone decides whether their contents are used.
        if (i_fill) begin
            r_tag  <= i_tag;
            r_data <= i_fill_data;
        end else if (i_upd && w_upd_match) begin
            for (int b = 0; b < 4; b++) begin
                if (i_upd_sel[b]) r_data[8*b +: 8] <= i_upd_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_bridge_s16_m32.sv
// Wishbone upsizing bridge: 16-bit slave port to 32-bit classic master port.
// Optional read buffer enabled by defining WB_BRIDGE_RDBUF_EN.
module wb_bridge_s16_m32
    import wb_bridge_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.slave  wb_s,
    wshb_if_DATA_BYTES_4_ADDRESS_WIDTH_32.master wb_m,
    input  logic                                 flush
);
    state_t      r_state;
    logic        r_cyc;
    logic        r_we;
    logic        r_hw_hi;
    logic        r_s_ack;
    logic        r_s_err;
    logic [31:0] r_adr;
    logic [31:0] r_dat_ms;
    logic [3:0]  r_sel;
    logic [15:0] r_s_dat_sm;

    logic        w_req;
    logic        w_hit;
    logic [15:0] w_hit_half;
    logic [3:0]  w_rd_sel;
    logic        w_unused_ok;

    assign w_req = wb_s.cyc && wb_s.stb;

`ifdef WB_BRIDGE_RDBUF_EN
    logic        w_buf_hit;
    logic [31:0] w_buf_data;
    logic        w_fill;
    logic        w_upd;
    logic        w_inval;

    assign w_fill  = (r_state == MREQ) && wb_m.ack && !r_we;
    assign w_upd   = (r_state == MREQ) && wb_m.ack && r_we;
    assign w_inval = flush || ((r_state == MREQ) && !wb_m.ack && wb_m.err);

    wb_rdbuf u_rdbuf (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (w_inval),
        .i_fill       (w_fill),
        .i_upd        (w_upd),
        .i_tag        (r_adr[31:2]),
        .i_fill_data  (wb_m.dat_sm),
        .i_upd_sel    (r_sel),
        .i_upd_data   (r_dat_ms),
        .i_lookup_tag (wb_s.adr[31:2]),
        .o_hit        (w_buf_hit),
        .o_data       (w_buf_data)
    );

    assign w_hit      = !wb_s.we && w_buf_hit;
    assign w_hit_half = wb_s.adr[1] ? w_buf_data[31:16] : w_buf_data[15:0];
    // Fetch the whole word so the other half-word can be served from the buffer.
    assign w_rd_sel   = 4'b1111;
`else
    assign w_hit      = 1'b0;
    assign w_hit_half = 16'h0000;
    assign w_rd_sel   = steer_sel(wb_s.adr[1], wb_s.sel);
`endif

    // Inputs with no function in this bridge.
    assign w_unused_ok = &{1'b0, flush, wb_m.rty, wb_s.adr[0], wb_s.cti, wb_s.bte};

    assign wb_m.cyc    = r_cyc;
    assign wb_m.stb    = r_cyc;
    assign wb_m.we     = r_we;
    assign wb_m.adr    = r_adr;
    assign wb_m.sel    = r_sel;
    assign wb_m.dat_ms = r_dat_ms;
    assign wb_m.cti    = CTI_CLASSIC;
    assign wb_m.bte    = BTE_LINEAR;

    assign wb_s.ack    = r_s_ack;
    assign wb_s.err    = r_s_err;
    assign wb_s.rty    = 1'b0;
    assign wb_s.dat_sm = r_s_dat_sm;

    // Access sequencer: accepts a slave request in IDLE, runs one master cycle or a buffer hit,
    // and returns a one-cycle ack/err with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 32'h0;
            r_dat_ms   <= 32'h0;
            r_sel      <= 4'h0;
            r_hw_hi    <= 1'b0;
            r_s_ack    <= 1'b0;
            r_s_err    <= 1'b0;
            r_s_dat_sm <= 16'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_hw_hi <= wb_s.adr[1];
                        if (w_hit) begin
                            r_state    <= ACK;
                            r_s_ack    <= 1'b1;
                            r_s_dat_sm <= w_hit_half;
                        end else begin
                            r_state  <= MREQ;
                            r_cyc    <= 1'b1;
                            r_we     <= wb_s.we;
                            r_adr    <= {wb_s.adr[31:2], 2'b00};
                            r_sel    <= wb_s.we ? steer_sel(wb_s.adr[1], wb_s.sel) : w_rd_sel;
                            r_dat_ms <= {wb_s.dat_ms, wb_s.dat_ms};
                        end
                    end
                end
                MREQ: begin
                    if (wb_m.ack) begin
                        r_state <= ACK;
                        r_cyc   <= 1'b0;
                        r_s_ack <= 1'b1;
                        if (!r_we) r_s_dat_sm <= r_hw_hi ? wb_m.dat_sm[31:16] : wb_m.dat_sm[15:0];
                    end else if (wb_m.err) begin
                        r_state <= ERR;
                        r_cyc   <= 1'b0;
                        r_s_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s_ack <= 1'b0;
                    r_s_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bridge_s16_m32.sv
// Self-checking bench for wb_bridge_s16_m32; adapts to WB_BRIDGE_RDBUF_EN.
module tb_wb_bridge_s16_m32;

`ifdef WB_BRIDGE_RDBUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic flush;

    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 sif (.clk(clk));
    wshb_if_DATA_BYTES_4_ADDRESS_WIDTH_32 mif (.clk(clk));

    wb_bridge_s16_m32 dut (
        .clk   (clk),
        .rst   (rst),
        .wb_s  (sif),
        .wb_m  (mif),
        .flush (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural memory behind the 32-bit port, indexed by word address.
    logic [31:0] mem [logic [29:0]];

    // Read-buffer model.
    bit          mb_valid = 1'b0;
    logic [29:0] mb_tag   = '0;
    logic [31:0] mb_data  = '0;

    // Expected master command for the access in progress.
    bit          exp_mcyc   = 1'b0;
    logic [31:0] exp_adr    = '0;
    logic        exp_we     = 1'b0;
    logic [3:0]  exp_sel    = '0;
    logic [31:0] exp_dat_ms = '0;

    // Responder controls and observations.
    bit          g_resp_en = 1'b1;
    bit          g_err     = 1'b0;
    int          g_wait    = 0;
    int          m_cnt     = 0;
    logic [3:0]  last_sel  = '0;
    logic [31:0] last_dat  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // 32-bit slave: acks (or errs) after g_wait extra cycles, reads/writes mem.
    initial begin : responder
        logic [31:0] w;
        mif.ack    = 1'b0;
        mif.err    = 1'b0;
        mif.rty    = 1'b0;
        mif.dat_sm = 32'h0;
        forever begin
            int wcnt;
            @(negedge clk);
            if (g_resp_en) begin
                mif.ack = 1'b0;
                mif.err = 1'b0;
                if (mif.cyc && mif.stb && !rst) begin
                    if (wcnt >= g_wait) begin
                        wcnt = 0;
                        m_cnt++;
                        last_sel = mif.sel;
                        last_dat = mif.dat_ms;
                        if (g_err) begin
                            mif.err = 1'b1;
                        end else begin
                            mif.ack = 1'b1;
                            w = mem_rd(mif.adr[31:2]);
                            if (mif.we) begin
                                for (int b = 0; b < 4; b++)
                                    if (mif.sel[b]) w[8*b +: 8] = mif.dat_ms[8*b +: 8];
                                mem[mif.adr[31:2]] = w;
                            end else begin
                                mif.dat_sm = w;
                            end
                        end
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Per-cycle compare of the master port against the expected command.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("m_stb_eq_cyc", 32'(mif.stb), 32'(mif.cyc));
                check("s_rty", 32'(sif.rty), 32'h0);
                if (mif.cyc) begin
                    check("m_cyc_expected", 32'(exp_mcyc), 32'h1);
                    check("m_adr", mif.adr, exp_adr);
                    check("m_we", 32'(mif.we), 32'(exp_we));
                    check("m_sel", 32'(mif.sel), 32'(exp_sel));
                    check("m_cti", 32'(mif.cti), 32'h0);
                    check("m_bte", 32'(mif.bte), 32'h0);
                    if (exp_we) check("m_dat_ms", mif.dat_ms, exp_dat_ms);
                end
            end
        end
    end

    // One 16-bit access; expectations come from the memory and buffer models.
    task automatic access(input logic we, input logic [31:0] adr, input logic [1:0] sel,
                          input logic [15:0] dat, input bit err, input int waits,
                          input int flush_at, output logic [15:0] rdata, output int lat);
        logic [31:0] word;
        bit          hit;
        int          m_before;
        int          cycles;
        bit          got;
        hit  = BUF_EN && !we && mb_valid && (mb_tag == adr[31:2]);
        word = hit ? mb_data : mem_rd(adr[31:2]);
        @(negedge clk);
        exp_mcyc   = !hit;
        exp_adr    = {adr[31:2], 2'b00};
        exp_we     = we;
        exp_sel    = (!we && BUF_EN) ? 4'hF : (adr[1] ? {sel, 2'b00} : {2'b00, sel});
        exp_dat_ms = {dat, dat};
        g_err      = err;
        g_wait     = waits;
        m_before   = m_cnt;
        sif.cyc    = 1'b1;
        sif.stb    = 1'b1;
        sif.we     = we;
        sif.adr    = adr;
        sif.sel    = sel;
        sif.dat_ms = dat;
        @(posedge clk);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            flush = (cycles == flush_at);
            if (sif.ack || sif.err) got = 1'b1;
        end
        sif.cyc = 1'b0;
        sif.stb = 1'b0;
        flush   = 1'b0;
        check("resp_seen", 32'(got), 32'h1);
        check("s_ack", 32'(sif.ack), 32'(!err));
        check("s_err", 32'(sif.err), 32'(err));
        if (!we && !err) check("s_dat_sm", 32'(sif.dat_sm), 32'(adr[1] ? word[31:16] : word[15:0]));
        check("latency", cycles, hit ? 1 : waits + 2);
        check("m_cycles", m_cnt - m_before, hit ? 0 : 1);
        rdata    = sif.dat_sm;
        lat      = cycles;
        exp_mcyc = 1'b0;
        g_err    = 1'b0;
        if (BUF_EN) begin
            if (err) begin
                mb_valid = 1'b0;
            end else if (!we && !hit) begin
                mb_valid = 1'b1;
                mb_tag   = adr[31:2];
                mb_data  = word;
            end else if (we && mb_valid && mb_tag == adr[31:2]) begin
                for (int b = 0; b < 4; b++)
                    if (exp_sel[b]) mb_data[8*b +: 8] = exp_dat_ms[8*b +: 8];
            end
            if (flush_at >= 0) mb_valid = 1'b0;
        end
        @(negedge clk);
        check("s_ack_pulse", 32'(sif.ack), 32'h0);
        check("s_err_pulse", 32'(sif.err), 32'h0);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (BUF_EN) mb_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [15:0] rd;
        int          lat;
        int          m0;
        rst        = 1'b1;
        flush      = 1'b0;
        sif.cyc    = 1'b0;
        sif.stb    = 1'b0;
        sif.we     = 1'b0;
        sif.adr    = 32'h0;
        sif.sel    = 2'b00;
        sif.dat_ms = 16'h0;
        sif.cti    = 3'b000;
        sif.bte    = 2'b00;
        mem[30'h100 >> 2] = 32'hAABBCCDD;
        mem[30'h200 >> 2] = 32'h11223344;
        mem[30'h300 >> 2] = 32'h55667788;
        mem[30'h400 >> 2] = 32'h99AA0011;

        repeat (3) @(negedge clk);
        check("rst_m_cyc", 32'(mif.cyc), 32'h0);
        check("rst_m_we", 32'(mif.we), 32'h0);
        check("rst_m_sel", 32'(mif.sel), 32'h0);
        check("rst_m_adr", mif.adr, 32'h0);
        check("rst_m_dat", mif.dat_ms, 32'h0);
        check("rst_s_ack", 32'(sif.ack), 32'h0);
        check("rst_s_err", 32'(sif.err), 32'h0);
        check("rst_s_dat", 32'(sif.dat_sm), 32'h0);
        rst = 1'b0;

        // Fill read then the neighbouring half-word.
        access(1'b0, 32'h100, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_0x100", 32'(rd), 32'h0000CCDD);
`ifdef WB_BRIDGE_RDBUF_EN
        check("fill_sel", 32'(last_sel), 32'hF);
`else
        check("fill_sel", 32'(last_sel), 32'h3);
`endif
        access(1'b0, 32'h102, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_0x102", 32'(rd), 32'h0000AABB);
`ifdef WB_BRIDGE_RDBUF_EN
        check("hit_latency", lat, 1);
`endif

        // Writes patch the buffered word.
        access(1'b1, 32'h102, 2'b01, 16'h0055, 1'b0, 0, -1, rd, lat);
        check("wr_sel_hi", 32'(last_sel), 32'h4);
        check("wr_dat_hi", last_dat, 32'h00550055);
        access(1'b0, 32'h102, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_after_wr", 32'(rd), 32'h0000AA55);
        access(1'b1, 32'h100, 2'b10, 16'h1200, 1'b0, 2, -1, rd, lat);
        check("wr_sel_lo", 32'(last_sel), 32'h2);
        check("wr_wait_lat", lat, 4);
        access(1'b0, 32'h100, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_after_wr_lo", 32'(rd), 32'h000012DD);

        // Flush forces the next read to miss.
        pulse_flush();
        m0 = m_cnt;
        access(1'b0, 32'h102, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("flush_miss", m_cnt - m0, 1);

        // Master error, then a read of the same word misses.
        access(1'b0, 32'h200, 2'b11, 16'h0, 1'b1, 0, -1, rd, lat);
        m0 = m_cnt;
        access(1'b0, 32'h202, 2'b11, 16'h0, 1'b0, 1, -1, rd, lat);
        check("rd_after_err", 32'(rd), 32'h00001122);
        check("err_miss", m_cnt - m0, 1);

        // Flush coinciding with the fill: access completes, buffer stays invalid.
        access(1'b0, 32'h400, 2'b11, 16'h0, 1'b0, 1, 2, rd, lat);
        check("rd_flush_fill", 32'(rd), 32'h00000011);
        m0 = m_cnt;
        access(1'b0, 32'h402, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_0x402", 32'(rd), 32'h000099AA);
        check("flush_fill_miss", m_cnt - m0, 1);

        // Reset while the master cycle is outstanding.
        access(1'b0, 32'h100, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        g_resp_en = 1'b0;
        @(negedge clk);
        exp_mcyc   = 1'b1;
        exp_adr    = 32'h300;
        exp_we     = 1'b0;
        exp_sel    = BUF_EN ? 4'hF : 4'h3;
        exp_dat_ms = 32'h0;
        sif.cyc    = 1'b1;
        sif.stb    = 1'b1;
        sif.we     = 1'b0;
        sif.adr    = 32'h300;
        sif.sel    = 2'b11;
        sif.dat_ms = 16'h0;
        @(negedge clk);
        check("mreq_cyc", 32'(mif.cyc), 32'h1);
        @(negedge clk);
        check("mreq_hold", 32'(mif.cyc), 32'h1);
        rst     = 1'b1;
        sif.cyc = 1'b0;
        sif.stb = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc", 32'(mif.cyc), 32'h0);
        check("rst_mid_stb", 32'(mif.stb), 32'h0);
        check("rst_mid_ack", 32'(sif.ack), 32'h0);
        exp_mcyc   = 1'b0;
        rst        = 1'b0;
        mif.ack    = 1'b1;
        mif.dat_sm = 32'hDEADBEEF;
        @(negedge clk);
        check("late_ack_0", 32'(sif.ack), 32'h0);
        mif.ack = 1'b0;
        @(negedge clk);
        check("late_ack_1", 32'(sif.ack), 32'h0);
        check("late_err", 32'(sif.err), 32'h0);
        mb_valid  = 1'b0;
        g_resp_en = 1'b1;
        m0 = m_cnt;
        access(1'b0, 32'h102, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_after_rst", 32'(rd), 32'h0000AA55);
        check("rst_miss", m_cnt - m0, 1);

        // Repeated read of one half-word.
        m0 = m_cnt;
        access(1'b0, 32'h302, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_0x302_a", 32'(rd), 32'h00005566);
`ifndef WB_BRIDGE_RDBUF_EN
        check("nobuf_sel_a", 32'(last_sel), 32'hC);
`endif
        access(1'b0, 32'h302, 2'b11, 16'h0, 1'b0, 0, -1, rd, lat);
        check("rd_0x302_b", 32'(rd), 32'h00005566);
`ifdef WB_BRIDGE_RDBUF_EN
        check("repeat_mcycles", m_cnt - m0, 1);
`else
        check("nobuf_sel_b", 32'(last_sel), 32'hC);
        check("repeat_mcycles", m_cnt - m0, 2);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
